// File: rtl/scrambler2_pkg.sv
// rtl/scrambler2_pkg.sv - state encoding, mux selects and output decode for the shuffle sequencer
package scrambler2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        CHECK  = 3'd2,
        LOAD_J = 3'd3,
        READ_I = 3'd4,
        WR_I   = 3'd5,
        WR_J   = 3'd6,
        INC    = 3'd7
    } state_t;

    localparam logic SI_ZERO   = 1'b0;
    localparam logic SI_INC    = 1'b1;
    localparam logic ADDR_I    = 1'b0;
    localparam logic ADDR_J    = 1'b1;
    localparam logic DIN_RDATA = 1'b0;
    localparam logic DIN_TEMP  = 1'b1;

    typedef struct packed {
        logic busy;
        logic en_i;
        logic s_i;
        logic en_j;
        logic s_r_addr;
        logic en_temp;
        logic s_w_addr;
        logic s_din;
        logic wr_en;
    } ctrl_t;

    function automatic ctrl_t state_outputs(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            INIT: begin
                c.busy = 1'b1;
                c.en_i = 1'b1;
                c.s_i  = SI_ZERO;
            end
            CHECK:  c.busy = 1'b1;
            LOAD_J: begin
                c.busy = 1'b1;
                c.en_j = 1'b1;
            end
            READ_I: begin
                c.busy     = 1'b1;
                c.s_r_addr = ADDR_I;
                c.en_temp  = 1'b1;
            end
            // mem[i] <= mem[j]: read j, write i
            WR_I: begin
                c.busy     = 1'b1;
                c.s_r_addr = ADDR_J;
                c.s_w_addr = ADDR_I;
                c.s_din    = DIN_RDATA;
                c.wr_en    = 1'b1;
            end
            WR_J: begin
                c.busy     = 1'b1;
                c.s_w_addr = ADDR_J;
                c.s_din    = DIN_TEMP;
                c.wr_en    = 1'b1;
            end
            INC: begin
                c.busy = 1'b1;
                c.en_i = 1'b1;
                c.s_i  = SI_INC;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/scrambler2_controller.sv
// rtl/scrambler2_controller.sv - Moore sequencer for an in-place regfile shuffle; optional done pulse via SCRAMBLER2_DONE_PULSE_EN
module scrambler2_controller
    import scrambler2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic i_lt_len_1,
`ifdef SCRAMBLER2_DONE_PULSE_EN
    output logic done,
`endif
    output logic en_i,
    output logic s_i,
    output logic en_j,
    output logic s_r_addr,
    output logic en_temp,
    output logic s_w_addr,
    output logic s_din,
    output logic wr_en,
    output logic busy
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? INIT : IDLE;
            INIT:    state_nxt = CHECK;
            CHECK:   state_nxt = i_lt_len_1 ? LOAD_J : IDLE;
            LOAD_J:  state_nxt = READ_I;
            READ_I:  state_nxt = WR_I;
            WR_I:    state_nxt = WR_J;
            WR_J:    state_nxt = INC;
            INC:     state_nxt = CHECK;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the decode of the next state so they track state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ctrl_q <= '0;
`ifdef SCRAMBLER2_DONE_PULSE_EN
            done   <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            ctrl_q <= state_outputs(state_nxt);
`ifdef SCRAMBLER2_DONE_PULSE_EN
            done   <= (state == CHECK) && !i_lt_len_1;
`endif
        end
    end

    assign busy     = ctrl_q.busy;
    assign en_i     = ctrl_q.en_i;
    assign s_i      = ctrl_q.s_i;
    assign en_j     = ctrl_q.en_j;
    assign s_r_addr = ctrl_q.s_r_addr;
    assign en_temp  = ctrl_q.en_temp;
    assign s_w_addr = ctrl_q.s_w_addr;
    assign s_din    = ctrl_q.s_din;
    assign wr_en    = ctrl_q.wr_en;

endmodule

// File: tb/tb_scrambler2_controller.sv
// tb/tb_scrambler2_controller.sv - directed vector bench for the shuffle sequencer
module tb_scrambler2_controller;

    // {busy,en_i,s_i,en_j,s_r_addr,en_temp,s_w_addr,s_din,wr_en}
    localparam logic [8:0] O_IDLE   = 9'b000000000;
    localparam logic [8:0] O_INIT   = 9'b110000000;
    localparam logic [8:0] O_CHECK  = 9'b100000000;
    localparam logic [8:0] O_LOAD_J = 9'b100100000;
    localparam logic [8:0] O_READ_I = 9'b100001000;
    localparam logic [8:0] O_WR_I   = 9'b100010001;
    localparam logic [8:0] O_WR_J   = 9'b100000111;
    localparam logic [8:0] O_INC    = 9'b111000000;

    typedef struct packed {
        logic       start;
        logic       ilt;
        logic [8:0] exp;
        logic       done;
    } vec_t;

    logic clk;
    logic rst_n;
    logic start;
    logic i_lt_len_1;
    logic en_i, s_i, en_j, s_r_addr, en_temp, s_w_addr, s_din, wr_en, busy;
    logic done_obs;
    logic [8:0] outs;

    int n_pass;
    int n_total;

    vec_t vecs [26];

`ifdef SCRAMBLER2_DONE_PULSE_EN
    logic done;
    assign done_obs = done;
`else
    assign done_obs = 1'b0;
`endif

    assign outs = {busy, en_i, s_i, en_j, s_r_addr, en_temp, s_w_addr, s_din, wr_en};

    scrambler2_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .i_lt_len_1 (i_lt_len_1),
`ifdef SCRAMBLER2_DONE_PULSE_EN
        .done       (done),
`endif
        .en_i       (en_i),
        .s_i        (s_i),
        .en_j       (en_j),
        .s_r_addr   (s_r_addr),
        .en_temp    (en_temp),
        .s_w_addr   (s_w_addr),
        .s_din      (s_din),
        .wr_en      (wr_en),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk_done(input string name, input logic exp);
`ifdef SCRAMBLER2_DONE_PULSE_EN
        chk(name, {8'd0, done_obs}, {8'd0, exp});
`else
        if (exp === 1'bx) chk(name, 9'd0, 9'd1);
`endif
    endtask

    task automatic step(input logic s, input logic l);
        start      = s;
        i_lt_len_1 = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // normal run: start held 2 cycles, start toggled mid-run, i_lt_len_1 drops during WR_J
        vecs[0]  = '{1'b1, 1'b1, O_INIT,   1'b0};
        vecs[1]  = '{1'b1, 1'b1, O_CHECK,  1'b0};
        vecs[2]  = '{1'b0, 1'b1, O_LOAD_J, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, O_READ_I, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, O_WR_I,   1'b0};
        vecs[5]  = '{1'b1, 1'b1, O_WR_J,   1'b0};
        vecs[6]  = '{1'b0, 1'b1, O_INC,    1'b0};
        vecs[7]  = '{1'b0, 1'b1, O_CHECK,  1'b0};
        vecs[8]  = '{1'b0, 1'b1, O_LOAD_J, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, O_READ_I, 1'b0};
        vecs[10] = '{1'b0, 1'b1, O_WR_I,   1'b0};
        vecs[11] = '{1'b0, 1'b0, O_WR_J,   1'b0};
        vecs[12] = '{1'b0, 1'b0, O_INC,    1'b0};
        vecs[13] = '{1'b0, 1'b0, O_CHECK,  1'b0};
        vecs[14] = '{1'b0, 1'b0, O_IDLE,   1'b1};
        vecs[15] = '{1'b0, 1'b0, O_IDLE,   1'b0};
        // len <= 1: INIT, CHECK, IDLE with no writes
        vecs[16] = '{1'b1, 1'b0, O_INIT,   1'b0};
        vecs[17] = '{1'b0, 1'b0, O_CHECK,  1'b0};
        vecs[18] = '{1'b0, 1'b0, O_IDLE,   1'b1};
        vecs[19] = '{1'b0, 1'b0, O_IDLE,   1'b0};
        // start held across completion: one IDLE cycle then a new run
        vecs[20] = '{1'b1, 1'b0, O_INIT,   1'b0};
        vecs[21] = '{1'b1, 1'b0, O_CHECK,  1'b0};
        vecs[22] = '{1'b1, 1'b0, O_IDLE,   1'b1};
        vecs[23] = '{1'b1, 1'b0, O_INIT,   1'b0};
        vecs[24] = '{1'b0, 1'b0, O_CHECK,  1'b0};
        vecs[25] = '{1'b0, 1'b0, O_IDLE,   1'b1};

        rst_n      = 1'b0;
        start      = 1'b0;
        i_lt_len_1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs, O_IDLE);
        chk_done("reset_done", 1'b0);
        rst_n = 1'b1;

        step(1'b0, 1'b1);
        chk("idle_no_start", outs, O_IDLE);

        for (int k = 0; k < 26; k++) begin
            step(vecs[k].start, vecs[k].ilt);
            chk($sformatf("vec%0d_outs", k), outs, vecs[k].exp);
            chk_done($sformatf("vec%0d_done", k), vecs[k].done);
        end

        // reset asserted while in WR_I takes effect without a clock edge
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("abort_pre_wr_i", outs, O_WR_I);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {8'd0, busy}, 9'd0);
        chk("abort_wr_en", {8'd0, wr_en}, 9'd0);
        step(1'b1, 1'b1);
        chk("abort_held", outs, O_IDLE);
        chk_done("abort_held_done", 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        chk("abort_release", outs, O_IDLE);
        chk_done("abort_release_done", 1'b0);
        step(1'b0, 1'b1);
        chk("abort_stay_idle", outs, O_IDLE);
        chk_done("abort_stay_done", 1'b0);
        step(1'b1, 1'b0);
        chk("restart_init", outs, O_INIT);
        step(1'b0, 1'b0);
        chk("restart_check", outs, O_CHECK);
        step(1'b0, 1'b0);
        chk("restart_idle", outs, O_IDLE);
        chk_done("restart_done", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
